// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the IO port arbiter.
//   io_state_t     - arbiter FSM states
//   IO_ADDR_W      - port bus address width
//   IO_NPORTS      - number of decoded IO ports
//   IO_ADDR_MAX    - highest valid port address
//   addr_in_range  - 1 when an address selects an existing port
package io_pkg;

    localparam int unsigned IO_ADDR_W = 4;
    localparam int unsigned IO_NPORTS = 4;
    localparam logic [IO_ADDR_W-1:0] IO_ADDR_MAX = IO_ADDR_W'(IO_NPORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } io_state_t;

    function automatic logic addr_in_range(input logic [IO_ADDR_W-1:0] a);
        return a <= IO_ADDR_MAX;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req         - request vector
//   last_winner - index of the previous winner; search starts just above it
//   winner      - one-hot winner (0 when no request)
//   winner_idx  - binary index of the winner
//   valid       - at least one request present
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_winner,
    output logic [NREQ-1:0] winner,
    output logic [IDXW-1:0] winner_idx,
    output logic            valid
);

    // Walk candidates last+1, last+2, ... with wrap; the previous winner is tried last.
    always_comb begin
        int unsigned cand;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_winner) + k) % NREQ;
            if (!valid && req[IDXW'(cand)]) begin
                valid                   = 1'b1;
                winner[IDXW'(cand)]     = 1'b1;
                winner_idx              = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/io_arbiter.sv
// io_arbiter: round-robin arbiter granting NREQ requesters single-cycle
// accesses to a shared IO port bus. One transaction takes three cycles
// (IDLE grant, ACCESS, DONE).
//   clk, rst          - clock, asynchronous active-high reset
//   req/we/addr/wdata - per-requester request, direction, address, write data
//   gnt               - one-hot owner of the current transaction
//   done/err          - completion pulse and out-of-range flag
//   rdata             - read data of the last completed transaction
//   busy              - transaction in progress
//   io_en/io_rw/io_addr/io_wdata/io_rdata - IO port bus
module io_arbiter
    import io_pkg::*;
#(
    parameter int unsigned BITS = 16,
    parameter int unsigned NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           we,
    input  logic [IO_ADDR_W*NREQ-1:0] addr,
    input  logic [BITS*NREQ-1:0]      wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic [BITS-1:0]           rdata,
    output logic                      busy,
    output logic                      io_en,
    output logic                      io_rw,
    output logic [IO_ADDR_W-1:0]      io_addr,
    output logic [BITS-1:0]           io_wdata,
    input  logic [BITS-1:0]           io_rdata
);

    localparam int unsigned IDXW = $clog2(NREQ);

    io_state_t             state;
    logic [IDXW-1:0]       last_winner;
    logic [IDXW-1:0]       cur_idx;
    logic [NREQ-1:0]       pick_onehot;
    logic [IDXW-1:0]       pick_idx;
    logic                  pick_valid;
    logic [IO_ADDR_W-1:0]  addr_arr  [NREQ];
    logic [BITS-1:0]       wdata_arr [NREQ];

    // Unpack per-requester address and write-data slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign addr_arr[g]  = addr[IO_ADDR_W*g +: IO_ADDR_W];
        assign wdata_arr[g] = wdata[BITS*g +: BITS];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req         (req),
        .last_winner (last_winner),
        .winner      (pick_onehot),
        .winner_idx  (pick_idx),
        .valid       (pick_valid)
    );

    // Arbiter FSM; the io_* registers double as the frozen copy of the granted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            done        <= '0;
            err         <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
            io_en       <= 1'b0;
            io_rw       <= 1'b0;
            io_addr     <= '0;
            io_wdata    <= '0;
            cur_idx     <= '0;
            last_winner <= IDXW'(NREQ - 1);
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state    <= ST_ACCESS;
                        busy     <= 1'b1;
                        gnt      <= pick_onehot;
                        cur_idx  <= pick_idx;
                        io_rw    <= we[pick_idx];
                        io_addr  <= addr_arr[pick_idx];
                        io_wdata <= wdata_arr[pick_idx];
                        // Out-of-range accesses never reach the bus.
                        io_en    <= addr_in_range(addr_arr[pick_idx]);
                    end
                end
                ST_ACCESS: begin
                    state <= ST_DONE;
                    io_en <= 1'b0;
                    done  <= gnt;
                    err   <= !addr_in_range(io_addr);
                    if (!io_rw && addr_in_range(io_addr)) begin
                        rdata <= io_rdata;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    gnt         <= '0;
                    last_winner <= cur_idx;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    gnt   <= '0;
                    io_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed bench for io_arbiter with a transaction-level
// reference model compared every cycle plus hand-computed spot checks.
module tb_io_arbiter;

    localparam int BITS = 16;
    localparam int NREQ = 4;
    localparam int IW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [4*NREQ-1:0]     addr;
    logic [BITS*NREQ-1:0]  wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic [BITS-1:0]       rdata;
    logic                  busy;
    logic                  io_en;
    logic                  io_rw;
    logic [3:0]            io_addr;
    logic [BITS-1:0]       io_wdata;
    logic [BITS-1:0]       io_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    io_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .io_en    (io_en),
        .io_rw    (io_rw),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // IO port: 16 registers, accessed on the falling edge while io_en is high.
    logic [BITS-1:0] port_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) port_mem[i] = '0;
        port_mem[0] = 16'h1234;
        port_mem[2] = 16'h0001;
        port_mem[3] = 16'hBEEF;
        io_rdata = '0;
        forever begin
            @(negedge clk);
            if (io_en) begin
                if (io_rw) port_mem[io_addr] = io_wdata;
                else       io_rdata = port_mem[io_addr];
            end
        end
    end

    // Reference model: one transaction at a time, tracked by cycles since grant.
    bit              m_active;
    int              m_age;
    int              m_idx;
    int              m_last;
    bit              m_we;
    logic [3:0]      m_addr;
    logic [BITS-1:0] m_wdata;
    logic [BITS-1:0] m_rdata;
    bit              m_err;
    logic [BITS-1:0] m_mem [16];

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_idx    = 0;
        m_last   = NREQ - 1;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_rdata  = '0;
        m_err    = 1'b0;
    endtask

    task automatic model_step();
        if (!m_active) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (req[IW'(c)]) begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_idx    = c;
                    m_we     = we[IW'(c)];
                    m_addr   = 4'(addr >> (4*c));
                    m_wdata  = BITS'(wdata >> (BITS*c));
                    break;
                end
            end
        end else begin
            m_age++;
            if (m_age == 2) begin
                if (m_addr > 4'd3) begin
                    m_err = 1'b1;
                end else begin
                    m_err = 1'b0;
                    if (m_we) m_mem[m_addr] = m_wdata;
                    else      m_rdata = m_mem[m_addr];
                end
            end else begin
                m_active = 1'b0;
                m_last   = m_idx;
            end
        end
    endtask

    task automatic model_compare();
        logic [63:0] own;
        own = m_active ? (64'(1) << m_idx) : 64'(0);
        chk("gnt",      64'(gnt),      own);
        chk("done",     64'(done),     (m_active && m_age == 2) ? own : 64'(0));
        chk("busy",     64'(busy),     64'(m_active));
        chk("io_en",    64'(io_en),    64'(m_active && m_age == 1 && m_addr <= 4'd3));
        chk("io_rw",    64'(io_rw),    64'(m_we));
        chk("io_addr",  64'(io_addr),  64'(m_addr));
        chk("io_wdata", 64'(io_wdata), 64'(m_wdata));
        chk("err",      64'(err),      64'(m_err));
        chk("rdata",    64'(rdata),    64'(m_rdata));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_mem[0] = 16'h1234;
        m_mem[2] = 16'h0001;
        m_mem[3] = 16'hBEEF;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #1;
            model_compare();
        end
    end

    task automatic set_req(input int i, input bit r, input bit w,
                           input logic [3:0] a, input logic [BITS-1:0] d);
        req[IW'(i)] = r;
        we[IW'(i)]  = w;
        addr  = (addr & ~((4*NREQ)'(4'hF) << (4*i))) | ((4*NREQ)'(a) << (4*i));
        wdata = (wdata & ~((BITS*NREQ)'({BITS{1'b1}}) << (BITS*i))) |
                ((BITS*NREQ)'(d) << (BITS*i));
    endtask

    // Wait (bounded) for the next done pulse, sampled at the falling edge.
    task automatic wait_done(output int idx, output int t);
        bit seen;
        seen = 1'b0;
        idx  = -1;
        t    = cyc;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = 1'b1;
                t    = cyc;
                for (int i = 0; i < NREQ; i++) if (done[IW'(i)]) idx = i;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=pulse within 12 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int t;
        int tp;
        int t_rel;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        tp    = 0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt",   64'(gnt),     64'(0));
        chk("rst_busy",  64'(busy),    64'(0));
        chk("rst_io_en", 64'(io_en),   64'(0));
        chk("rst_rdata", 64'(rdata),   64'(0));

        // Contention: everyone reads its own port, held from reset.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 4'(i), '0);
        @(negedge clk);
        rst   = 1'b0;
        t_rel = cyc;
        for (int k = 0; k < 5; k++) begin
            wait_done(idx, t);
            chk("rr_order", 64'(idx), 64'(exp_order[k]));
            if (k == 0) chk("rr_first_latency", 64'(t - t_rel), 64'(2));
            else        chk("rr_spacing", 64'(t - tp), 64'(3));
            tp = t;
        end
        chk("rr_rdata", 64'(rdata), 64'(16'h1234));
        req = '0;

        // Fields frozen at grant; req drop does not abort.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd2, '0);
        @(negedge clk);
        chk("fz_io_en",   64'(io_en),   64'(1));
        chk("fz_io_addr", 64'(io_addr), 64'(2));
        chk("fz_gnt",     64'(gnt),     64'(4'b0001));
        set_req(0, 1'b0, 1'b1, 4'd3, 16'hFFFF);
        @(negedge clk);
        chk("fz_done",      64'(done),    64'(4'b0001));
        chk("fz_rdata",     64'(rdata),   64'(16'h0001));
        chk("fz_addr_hold", 64'(io_addr), 64'(2));
        set_req(0, 1'b0, 1'b0, 4'd0, '0);

        // Single read.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd2, '0);
        chk("rd_idle_io_en", 64'(io_en), 64'(0));
        @(negedge clk);
        chk("rd_io_en",   64'(io_en),   64'(1));
        chk("rd_io_rw",   64'(io_rw),   64'(0));
        chk("rd_io_addr", 64'(io_addr), 64'(2));
        @(negedge clk);
        chk("rd_done",    64'(done),  64'(4'b0001));
        chk("rd_rdata",   64'(rdata), 64'(16'h0001));
        chk("rd_err",     64'(err),   64'(0));
        chk("rd_io_en_off", 64'(io_en), 64'(0));
        set_req(0, 1'b0, 1'b0, 4'd0, '0);

        // Single write.
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 4'd1, 16'h0001);
        @(negedge clk);
        chk("wr_io_en",    64'(io_en),    64'(1));
        chk("wr_io_rw",    64'(io_rw),    64'(1));
        chk("wr_io_addr",  64'(io_addr),  64'(1));
        chk("wr_io_wdata", 64'(io_wdata), 64'(16'h0001));
        chk("wr_gnt",      64'(gnt),      64'(4'b0010));
        @(negedge clk);
        chk("wr_done",  64'(done),  64'(4'b0010));
        chk("wr_rdata", 64'(rdata), 64'(16'h0001));
        set_req(1, 1'b0, 1'b0, 4'd0, '0);

        // Out-of-range address.
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 4'd9, '0);
        @(negedge clk);
        chk("oor_io_en", 64'(io_en), 64'(0));
        chk("oor_busy",  64'(busy),  64'(1));
        chk("oor_gnt",   64'(gnt),   64'(4'b0100));
        @(negedge clk);
        chk("oor_done",  64'(done),  64'(4'b0100));
        chk("oor_err",   64'(err),   64'(1));
        chk("oor_rdata", 64'(rdata), 64'(16'h0001));
        set_req(2, 1'b0, 1'b0, 4'd0, '0);

        // Reset during ACCESS, then requester 3 wins first after release.
        @(negedge clk);
        set_req(3, 1'b1, 1'b0, 4'd3, '0);
        @(negedge clk);
        chk("ra_io_en_before", 64'(io_en), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("ra_io_en", 64'(io_en), 64'(0));
        chk("ra_gnt",   64'(gnt),   64'(0));
        chk("ra_err",   64'(err),   64'(0));
        @(negedge clk);
        chk("ra_no_done", 64'(done), 64'(0));
        rst = 1'b0;
        wait_done(idx, t);
        chk("ra_winner", 64'(idx),   64'(3));
        chk("ra_rdata",  64'(rdata), 64'(16'hBEEF));
        chk("ra_err2",   64'(err),   64'(0));
        set_req(3, 1'b0, 1'b0, 4'd0, '0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter BITS, default 16, data word width of the IO port bus.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester access request, level, held until done.
REQ-006 we  input  NREQ  per-requester direction: 1 = write, 0 = read.
REQ-007 addr  input  4*NREQ  per-requester IO port address; slice i is bits [4i+3:4i].
REQ-008 wdata  input  BITS*NREQ  per-requester write data; slice i is bits [BITS*i+BITS-1:BITS*i].
REQ-009 gnt  output  NREQ  one-hot, identifies the requester owning the current transaction.
REQ-010 done  output  NREQ  one-cycle pulse on the owning requester's bit when its transaction completes.
REQ-011 err  output  1  valid with done; 1 = address out of range (addr > 4'd3).
REQ-012 rdata  output  BITS  read data of the last completed transaction.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 io_en  output  1  port bus enable.
REQ-015 io_rw  output  1  port bus direction: 1 = write, 0 = read.
REQ-016 io_addr  output  4  port bus address.
REQ-017 io_wdata  output  BITS  port bus write data.
REQ-018 io_rdata  input  BITS  port bus read data; the port updates it on the falling clock edge while io_en is high.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE; encodings defined in the shared package.
REQ-020 IDLE: if any req bit is set, select the winner by round-robin, searching from (last_winner+1) mod NREQ upward with wrap; latch its we/addr/wdata; set gnt one-hot; go to ACCESS. Otherwise remain in IDLE with gnt=0.
REQ-021 ACCESS, lasting exactly one cycle: drive io_en=1 with the latched io_rw/io_addr/io_wdata.
REQ-022 ACCESS with a read: capture io_rdata into rdata on the rising edge that leaves ACCESS.
REQ-023 ACCESS with a write: leave rdata unchanged.
REQ-024 ACCESS with latched addr > 3: keep io_en=0, leave rdata unchanged, set the err flag.
REQ-025 DONE, lasting exactly one cycle: pulse the winner's done bit, present err, update last_winner, hold gnt, keep io_en=0, then go to IDLE.
REQ-026 io_en, io_rw, io_addr and io_wdata are registered outputs; io_en is 0 outside ACCESS; io_addr/io_wdata hold their last value outside ACCESS.
REQ-027 Latency: request seen in IDLE, then io_en one cycle later, then done two cycles later; 3 cycles per transaction; back-to-back transactions yield one transaction every 3 cycles.
REQ-028 Sampled fields are frozen at grant; changes to we/addr/wdata after grant do not affect the transaction.
REQ-029 A req drop after grant does not abort the transaction; done still pulses.
REQ-030 A requester whose req is still high in the IDLE cycle after its DONE is eligible, but ranks last in the round-robin order.
REQ-031 Simultaneous requests: exactly one grant; no requester waits more than NREQ-1 transactions.
REQ-032 rdata and err hold their values until the next DONE.

Reset
REQ-033 Asserting rst forces, immediately: state=IDLE, gnt=0, done=0, err=0, busy=0, io_en=0, io_rw=0, io_addr=0, io_wdata=0, rdata=0, last_winner=NREQ-1 (so requester 0 wins first).
REQ-034 Reset asserted during ACCESS or DONE aborts the transaction with no done pulse; io_en falls asynchronously.

Structure
REQ-035 Shared package io_pkg holds the FSM state typedef, IO_ADDR_W=4, IO_NPORTS=4 and the out-of-range address limit.
REQ-036 One sub-module, rr_pick: combinational round-robin selector taking (req, last_winner) and returning a one-hot winner plus its index.

Verification
REQ-037 Single read: req[0]=1, we=0, addr=2, io_rdata=16'h0001 in the ACCESS cycle -> io_en high for exactly 1 cycle with io_addr=2, done[0] pulse 2 cycles after grant, rdata=16'h0001, err=0.
REQ-038 Single write: req[1]=1, we=1, addr=1, wdata=16'h0001 -> one io_en cycle with io_rw=1, io_addr=1, io_wdata=16'h0001; done[1] pulse; rdata unchanged.
REQ-039 Contention: req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0, with done pulses 3 cycles apart.
REQ-040 Out of range: req[2]=1, addr=4'd9 -> io_en stays 0, done[2] pulse with err=1.
REQ-041 Reset mid-ACCESS: rst asserted in the io_en cycle -> io_en=0 immediately, no done pulse; after release, req[3] is granted normally.
REQ-042 Field change after grant: addr changes 2 -> 3 one cycle after grant -> io_addr=2 in ACCESS.
